// File: rtl/tc_pl_cap_seq.sv
// tc_pl_cap_seq
//
// Capture sequencer for one multi-gain acquisition. A rising edge on
// cap_trig starts a capture of n gain stages. Each stage first requests the
// gain/front-end configurator (gain_en / gain_cmpt). It then requests the
// data mover (data_en / data_cmpt). The block reports busy, completion,
// elapsed cycles and watchdog errors.
//
// Ports:
//   clk125       system clock
//   rst          asynchronous reset, active low
//   cap_trig     capture request level (rising edge starts a capture)
//   cap_abort    level, forces return to idle from any busy state
//   gain_number  requested stage count, latched at start (0 -> 1, clamped)
//   to_limit     watchdog limit in cycles per wait state, 0 disables
//   cap_cing     capture in progress
//   cap_cmpt     one-cycle pulse on successful completion
//   cap_err      one-cycle pulse on watchdog timeout
//   cap_time     cycles cap_cing was high in the last/current capture
//   gain_value   current gain stage index
//   gain_en      one-cycle request to the gain configurator
//   gain_cmpt    gain configurator done strobe
//   data_en      one-cycle request to the data mover
//   data_cmpt    data mover done strobe
//   dbg_state    current FSM state encoding
//
// Handshake: gain_en and data_en are single-cycle requests raised in the
// matching *_REQ state. The partner answers with a single-cycle *_cmpt
// strobe. The strobe is accepted only while the FSM sits in the matching
// *_WAIT state; at any other time it is dropped. No request is outstanding
// once the FSM has left the wait state, whether by completion, timeout or
// abort.
module tc_pl_cap_seq #(
  parameter int GN_W = 3,
  parameter int TM_W = 32,
  parameter int TO_W = 24
) (
  input  logic            clk125,
  input  logic            rst,
  input  logic            cap_trig,
  input  logic            cap_abort,
  input  logic [GN_W-1:0] gain_number,
  input  logic [TO_W-1:0] to_limit,
  output logic            cap_cing,
  output logic            cap_cmpt,
  output logic            cap_err,
  output logic [TM_W-1:0] cap_time,
  output logic [GN_W-2:0] gain_value,
  output logic            gain_en,
  input  logic            gain_cmpt,
  output logic            data_en,
  input  logic            data_cmpt,
  output logic [2:0]      dbg_state
);

  localparam int GV_W = GN_W - 1;
  localparam logic [GN_W-1:0] MAX_N = GN_W'(1 << GV_W);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GAIN_REQ  = 3'd1,
    S_GAIN_WAIT = 3'd2,
    S_DATA_REQ  = 3'd3,
    S_DATA_WAIT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            cap_trig_d;
  logic            trig_arm;
  logic            trig_start;
  logic            start;
  logic [GN_W-1:0] n_clamp;
  logic [GV_W-1:0] last_idx;
  logic [GV_W-1:0] last_idx_nxt;
  logic [TO_W-1:0] wd_cnt;
  logic [TO_W:0]   wd_cnt_inc;
  logic            in_wait;
  logic            wd_hit;
  logic            timeout;
  logic            advance;
  logic            busy_nxt;

  // A level that is already high when reset releases is not a rising edge:
  // trig_arm keeps the first post-reset cycle from being taken as a trigger
  // while cap_trig_d catches up with the input.
  assign trig_start = cap_trig & ~cap_trig_d & trig_arm;
  assign start      = (state == S_IDLE) && trig_start;
  assign in_wait    = (state == S_GAIN_WAIT) || (state == S_DATA_WAIT);

  // wd_cnt counts wait cycles already completed. The current cycle is the
  // (wd_cnt+1)-th in the wait state, so the limit is reached when that sum
  // meets to_limit. The extra bit keeps the compare clear of overflow.
  assign wd_cnt_inc = {1'b0, wd_cnt} + {{TO_W{1'b0}}, 1'b1};
  assign wd_hit     = (to_limit != '0) && (wd_cnt_inc >= {1'b0, to_limit});

  assign dbg_state  = state;

  // Stage count normalisation: 0 means one stage, above MAX_N clamps.
  always_comb begin
    n_clamp = gain_number;
    if (gain_number == '0) begin
      n_clamp = GN_W'(1);
    end else if (gain_number > MAX_N) begin
      n_clamp = MAX_N;
    end
    last_idx_nxt = GV_W'(n_clamp - GN_W'(1));
  end

  // Next-state logic. Priority is abort > timeout > completion strobe.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE:      if (trig_start) state_nxt = S_GAIN_REQ;
      S_GAIN_REQ:  state_nxt = S_GAIN_WAIT;
      S_GAIN_WAIT: begin
        if (wd_hit) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else if (gain_cmpt) begin
          state_nxt = S_DATA_REQ;
        end
      end
      S_DATA_REQ:  state_nxt = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (wd_hit) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else if (data_cmpt) begin
          if (gain_value == last_idx) begin
            state_nxt = S_DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = S_GAIN_REQ;
          end
        end
      end
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (cap_abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      timeout   = 1'b0;
      advance   = 1'b0;
    end
  end

  assign busy_nxt = (state_nxt == S_GAIN_REQ) || (state_nxt == S_GAIN_WAIT) ||
                    (state_nxt == S_DATA_REQ) || (state_nxt == S_DATA_WAIT);

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cap_trig_d <= 1'b0;
      trig_arm   <= 1'b0;
      last_idx   <= '0;
      wd_cnt     <= '0;
      cap_cing   <= 1'b0;
      cap_cmpt   <= 1'b0;
      cap_err    <= 1'b0;
      cap_time   <= '0;
      gain_value <= '0;
      gain_en    <= 1'b0;
      data_en    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cap_trig_d <= cap_trig;
      trig_arm   <= 1'b1;
      cap_cing   <= busy_nxt;
      cap_cmpt   <= (state_nxt == S_DONE);
      cap_err    <= timeout;
      gain_en    <= (state_nxt == S_GAIN_REQ);
      data_en    <= (state_nxt == S_DATA_REQ);

      if (start) begin
        last_idx <= last_idx_nxt;
      end

      // Cleared outside the wait states, so every wait starts from zero.
      if (in_wait) begin
        wd_cnt <= wd_cnt + TO_W'(1);
      end else begin
        wd_cnt <= '0;
      end

      if (start) begin
        gain_value <= '0;
      end else if (advance) begin
        gain_value <= gain_value + GV_W'(1);
      end

      // cap_cing is low on the start edge, so clearing there does not
      // lose a count; the value then holds through idle.
      if (start) begin
        cap_time <= '0;
      end else if (cap_cing && (cap_time != '1)) begin
        cap_time <= cap_time + TM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_seq.sv
// Testbench for tc_pl_cap_seq: fixed vector table, hand-written reset
// sequence and randomized captures against a stage-level reference model.
module tb_tc_pl_cap_seq;

  localparam int GN_W = 3;
  localparam int TM_W = 32;
  localparam int TO_W = 24;
  localparam int GV_W = GN_W - 1;

  // ---------------- clock / reset ----------------
  logic clk125 = 1'b0;
  logic rst    = 1'b0;
  always #4 clk125 = ~clk125;

  logic            cap_trig    = 1'b0;
  logic            cap_abort   = 1'b0;
  logic [GN_W-1:0] gain_number = '0;
  logic [TO_W-1:0] to_limit    = '0;
  logic            gain_cmpt   = 1'b0;
  logic            data_cmpt   = 1'b0;
  logic            cap_cing;
  logic            cap_cmpt;
  logic            cap_err;
  logic [TM_W-1:0] cap_time;
  logic [GV_W-1:0] gain_value;
  logic            gain_en;
  logic            data_en;
  logic [2:0]      dbg_state;

  tc_pl_cap_seq #(.GN_W(GN_W), .TM_W(TM_W), .TO_W(TO_W)) dut (
    .clk125      (clk125),
    .rst         (rst),
    .cap_trig    (cap_trig),
    .cap_abort   (cap_abort),
    .gain_number (gain_number),
    .to_limit    (to_limit),
    .cap_cing    (cap_cing),
    .cap_cmpt    (cap_cmpt),
    .cap_err     (cap_err),
    .cap_time    (cap_time),
    .gain_value  (gain_value),
    .gain_en     (gain_en),
    .gain_cmpt   (gain_cmpt),
    .data_en     (data_en),
    .data_cmpt   (data_cmpt),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [GV_W-1:0] exp_q[$];
  int dg_a[4];
  int dd_a[4];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Stage-level reference: each stage costs one request cycle plus the
  // responder delay, per handshake. A wait lasting at least the limit ends
  // the capture after limit+1 cycles for that handshake.
  task automatic model(input int gn, input int lim,
                       output int ng, output int nd, output int er, output int tm);
    int n;
    n  = (gn == 0) ? 1 : ((gn > 4) ? 4 : gn);
    ng = 0; nd = 0; er = 0; tm = 0;
    for (int k = 0; k < n && er == 0; k++) begin
      ng++;
      if (lim != 0 && dg_a[k] >= lim) begin
        tm += lim + 1; er = 1;
      end else begin
        tm += dg_a[k] + 1; nd++;
        if (lim != 0 && dd_a[k] >= lim) begin
          tm += lim + 1; er = 1;
        end else begin
          tm += dd_a[k] + 1;
        end
      end
    end
  endtask

  // ---------------- driver / responder ----------------
  // Cycle 0 is the first cycle after the edge that samples the trigger.
  task automatic run_capture(input int gn, input int lim, input int ab_stage,
                             input int ab_dly, input int hold, input int exp_ng,
                             input int exp_nd, input int exp_err, input int exp_time);
    int g_tmr, d_tmr, a_tmr;
    int ng, nd, ncm, ner, ncing, end_cyc, ev_cyc, exp_cmpt;
    g_tmr = 0; d_tmr = 0; a_tmr = 0;
    ng = 0; nd = 0; ncm = 0; ner = 0; ncing = 0; end_cyc = -1; ev_cyc = -1;
    exp_cmpt = (exp_err == 0 && ab_stage < 0) ? 1 : 0;
    exp_q.delete();
    for (int k = 0; k < exp_ng; k++) exp_q.push_back(GV_W'(k));

    @(posedge clk125); #1;
    gain_number = GN_W'(gn);
    to_limit    = TO_W'(lim);
    cap_trig    = 1'b0;
    @(posedge clk125); #1;
    cap_trig = 1'b1;

    for (int cyc = 0; cyc < exp_time + 30; cyc++) begin
      @(posedge clk125); #1;
      if (hold == 0)     cap_trig = 1'b0;
      else if (cyc == 5) cap_trig = 1'b0;
      else if (cyc == 7) cap_trig = 1'b1;

      if (cap_cing) ncing++;
      else if (end_cyc < 0) end_cyc = cyc;
      if (cap_cmpt) ncm++;
      if (cap_err) ner++;
      if ((cap_cmpt || cap_err) && ev_cyc < 0) ev_cyc = cyc;

      gain_cmpt = 1'b0;
      data_cmpt = 1'b0;
      cap_abort = 1'b0;
      if (g_tmr > 0) begin g_tmr--; if (g_tmr == 0) gain_cmpt = 1'b1; end
      if (d_tmr > 0) begin d_tmr--; if (d_tmr == 0) data_cmpt = 1'b1; end
      if (a_tmr > 0) begin a_tmr--; if (a_tmr == 0) cap_abort = 1'b1; end

      if (gain_en) begin
        ng++;
        if (exp_q.size() > 0) check("gain_value", gain_value, exp_q.pop_front());
        g_tmr = dg_a[(ng - 1) & 3];
      end
      if (data_en) begin
        nd++;
        d_tmr = dd_a[(nd - 1) & 3];
        if (nd - 1 == ab_stage) a_tmr = ab_dly;
      end
    end

    check("gain_en_count", ng, exp_ng);
    check("data_en_count", nd, exp_nd);
    check("cmpt_count", ncm, exp_cmpt);
    check("err_count", ner, exp_err);
    check("end_cycle", end_cyc, exp_time);
    check("event_cycle", ev_cyc, (exp_cmpt != 0 || exp_err != 0) ? exp_time : -1);
    check("cing_cycles", ncing, exp_time);
    check("cap_time", cap_time, exp_time);

    cap_trig  = 1'b0;
    gain_cmpt = 1'b0;
    data_cmpt = 1'b0;
    cap_abort = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int gn; int lim; int dg; int dd; int ab_stage; int ab_dly; int hold;
    int exp_ng; int exp_nd; int exp_err; int exp_time;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int gn, lim, eng, end_n, eer, etm, cnt_en, cnt_cing, cnt_ev;

    //        gn lim dg  dd ab  dly hold ng nd err time
    vecs[0] = '{2,  0, 5, 10, -1, 0, 0,  2, 2, 0,  34};
    vecs[1] = '{0,  0, 3,  4, -1, 0, 0,  1, 1, 0,   9};
    vecs[2] = '{7,  0, 2,  2, -1, 0, 0,  4, 4, 0,  24};
    vecs[3] = '{1,  0, 1,  1, -1, 0, 0,  1, 1, 0,   4};
    vecs[4] = '{2, 20, 25, 1, -1, 0, 0,  1, 0, 1,  21};
    vecs[5] = '{4, 30, 5,  5, -1, 0, 0,  4, 4, 0,  48};
    vecs[6] = '{3,  8, 2,  8, -1, 0, 0,  1, 1, 1,  12};
    vecs[7] = '{3,  8, 7,  7, -1, 0, 0,  3, 3, 0,  48};
    vecs[8] = '{2,  0, 3, 10,  1, 4, 0,  2, 2, 0,  24};
    vecs[9] = '{2,  0, 5, 10, -1, 0, 1,  2, 2, 0,  34};

    // Reset state while rst is held low.
    repeat (3) @(posedge clk125);
    #1;
    check("rst_cing", cap_cing, 0);
    check("rst_cmpt", cap_cmpt, 0);
    check("rst_err", cap_err, 0);
    check("rst_time", cap_time, 0);
    check("rst_gain_value", gain_value, 0);
    check("rst_gain_en", gain_en, 0);
    check("rst_data_en", data_en, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk125);
    rst = 1'b1;
    repeat (2) @(posedge clk125);

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        dg_a[k] = vecs[i].dg;
        dd_a[k] = vecs[i].dd;
      end
      run_capture(vecs[i].gn, vecs[i].lim, vecs[i].ab_stage, vecs[i].ab_dly,
                  vecs[i].hold, vecs[i].exp_ng, vecs[i].exp_nd,
                  vecs[i].exp_err, vecs[i].exp_time);
    end

    // Reset in the middle of GAIN_WAIT with the trigger left high.
    @(posedge clk125); #1;
    gain_number = 3'd2;
    to_limit    = '0;
    cap_trig    = 1'b0;
    @(posedge clk125); #1;
    cap_trig = 1'b1;
    repeat (4) @(posedge clk125);
    #1;
    check("pre_rst_cing", cap_cing, 1);
    check("pre_rst_state", dbg_state, 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_cing", cap_cing, 0);
    check("async_rst_time", cap_time, 0);
    check("async_rst_state", dbg_state, 0);
    check("async_rst_gain_en", gain_en, 0);
    @(negedge clk125);
    rst = 1'b1;
    cnt_en = 0; cnt_cing = 0; cnt_ev = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk125); #1;
      if (gain_en) cnt_en++;
      if (cap_cing) cnt_cing++;
      if (cap_cmpt || cap_err) cnt_ev++;
    end
    check("held_trig_gain_en", cnt_en, 0);
    check("held_trig_cing", cnt_cing, 0);
    check("held_trig_events", cnt_ev, 0);
    cap_trig = 1'b0;

    // Randomized captures against the model.
    for (int r = 0; r < 30; r++) begin
      gn  = $urandom_range(0, 7);
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 14);
      for (int k = 0; k < 4; k++) begin
        dg_a[k] = $urandom_range(1, 12);
        dd_a[k] = $urandom_range(1, 12);
      end
      model(gn, lim, eng, end_n, eer, etm);
      run_capture(gn, lim, -1, 0, 0, eng, end_n, eer, etm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tc_pl_cap_seq.md
Name: tc_pl_cap_seq

Overview:
Capture sequencer that drives one full multi-gain acquisition on the capture datapath. On a PS trigger it steps through the requested number of gain stages. For each stage it first hands off to the gain/front-end configurator (DAC, FDA, relays), then to the data mover that streams ADC samples to memory over ACP. It reports busy, completion, elapsed time and watchdog errors back to the PS register block.

Parameters:
GN_W, 3, width of gain_number; gain index width is GN_W-1.
TM_W, 32, width of the cap_time elapsed-cycle counter.
TO_W, 24, width of the per-handshake watchdog limit.

Ports:
clk125  in  1  system clock, 125 MHz.
rst  in  1  asynchronous active-low reset (0 = reset).
cap_trig  in  1  capture request level from PS registers; a rising edge starts a capture.
cap_abort  in  1  level; forces return to IDLE.
gain_number  in  GN_W  number of gain stages per capture; latched on start.
to_limit  in  TO_W  watchdog limit in cycles per wait state; 0 disables the watchdog.
cap_cing  out  1  capture in progress.
cap_cmpt  out  1  one-cycle pulse on successful completion.
cap_err  out  1  one-cycle pulse on watchdog timeout.
cap_time  out  TM_W  number of cycles cap_cing was high in the last or current capture.
gain_value  out  GN_W-1  current gain stage index.
gain_en  out  1  one-cycle request to the gain configurator.
gain_cmpt  in  1  gain configurator done strobe.
data_en  out  1  one-cycle request to the data mover.
data_cmpt  in  1  data mover done strobe.

Behaviour:
- Reset: all outputs are 0, state is IDLE, the trigger edge detector's "previous" flop is 0, and the watchdog count is 0. Reset asserted mid-capture aborts immediately, with no cmpt or err pulse.
- All outputs are registered. State decode feeds the flops, so there is no combinational path from input to output.
- Trigger edge: trig_start = cap_trig & ~cap_trig_d. It is honoured only in IDLE. Edges arriving while busy are ignored and not queued.
- Latched stage count, n: gain_number = 0 is treated as 1. A value above 2^(GN_W-1) is clamped to 2^(GN_W-1) (4 at default).
- States: IDLE, GAIN_REQ, GAIN_WAIT, DATA_REQ, DATA_WAIT, DONE.
- IDLE: on trig_start, the cycle after the sampling edge has cap_cing=1, gain_en=1 and gain_value=0, and state = GAIN_REQ. At that same edge cap_time is cleared to 0.
- GAIN_REQ: one cycle, then GAIN_WAIT. The watchdog is cleared.
- GAIN_WAIT: gain_cmpt sampled high moves to DATA_REQ, with data_en=1 in the following cycle.
- DATA_REQ: one cycle, then DATA_WAIT. The watchdog is cleared.
- DATA_WAIT: data_cmpt sampled high:
  - if gain_value == n-1, go to DONE;
  - otherwise gain_value+1 and GAIN_REQ, with gain_en pulsing the next cycle.
- DONE: cap_cmpt=1 for one cycle and cap_cing=0 in that same cycle, then IDLE.
- Completion strobes sampled in any state other than the matching WAIT state are ignored.
- cap_time: increments by 1 on every clock in which cap_cing=1. It saturates at all-ones and holds its value in IDLE until the next accepted trigger.
- Watchdog: counts clocks spent in GAIN_WAIT or DATA_WAIT. When to_limit != 0 and the count reaches to_limit without the strobe:
  - cap_err pulses for one cycle;
  - cap_cing=0 and state = IDLE;
  - no cap_cmpt pulse.
- Abort: cap_abort sampled high in any non-IDLE state moves to IDLE next cycle with cap_cing=0, no cmpt and no err.
- Priority when events coincide in the same cycle: abort > timeout > completion strobe.
- gain_value holds its last value in IDLE.

Test Plan:
- gain_number=2, to_limit=0; trig edge; gain_cmpt 5 cycles after each gain_en; data_cmpt 10 cycles after each data_en -> gain_en pulses with gain_value 0 then 1, two data_en pulses, one cap_cmpt pulse, cap_time equals the cycle count of cap_cing high.
- gain_number=0 -> exactly one gain/data round, then cap_cmpt. gain_number=7 with GN_W=3 -> exactly 4 rounds, gain_value 0..3.
- to_limit=20, gain_cmpt never arrives -> cap_err pulses 20 cycles into GAIN_WAIT, cap_cing falls, no cap_cmpt, a new trigger is accepted afterwards.
- cap_abort raised during DATA_WAIT of stage 1 -> IDLE next cycle, no cmpt/err, data_cmpt arriving afterwards is ignored.
- cap_trig held high through completion, then re-pulsed mid-capture -> only one capture runs per rising edge; the mid-capture edge is ignored.
- rst asserted low during GAIN_WAIT -> all outputs 0 asynchronously; after release cap_trig (still high) requires a fresh rising edge.
